// File: rtl/sort_test_sequencer_if.sv
// Memory bus between the sort test sequencer (master) and the memory / bus mux (slave).
// Carries the AW/W/B write channels and the AR/R read channels.
interface sort_test_sequencer_if #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
);
  logic                 aw_valid;
  logic                 aw_ready;
  logic [ADDR_WDTH-1:0] aw_address;
  logic                 w_valid;
  logic                 w_ready;
  logic [DATA_WDTH-1:0] w_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [RESP_WDTH-1:0] b_resp;
  logic                 ar_valid;
  logic                 ar_ready;
  logic [ADDR_WDTH-1:0] ar_address;
  logic                 r_valid;
  logic                 r_ready;
  logic [DATA_WDTH-1:0] r_data;
  logic [RESP_WDTH-1:0] r_resp;

  modport master (
    output aw_valid, aw_address, w_valid, w_data, b_ready, ar_valid, ar_address, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_address, w_valid, w_data, b_ready, ar_valid, ar_address, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/sort_test_sequencer.sv
// Self-checking test engine for sort_circuit: fills memory with LFSR words,
// hands the bus to the sorter, reads the array back and checks ascending order,
// NUM_RUNS times per go. Optional feature macro SORT_SUM_CHECK_EN adds a
// write/read sum comparison per run (error code 6).
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for go after reset
// S_FILL_REQ  | AW and W valid for element idx, each drops after its handshake
// S_FILL_RESP | waiting for the write response of element idx
// S_SORT      | bus granted to the sorter, sort_start high, timeout running
// S_CHK_REQ   | AR valid for element idx
// S_CHK_DATA  | waiting for read data of element idx, order check
// S_DONE      | sequence over, pass or fail held until the next go
module sort_test_sequencer #(
  parameter int          ADDR_WDTH   = 4,
  parameter int          DATA_WDTH   = 32,
  parameter int          RESP_WDTH   = 1,
  parameter int          NUM_RUNS    = 4,
  parameter int          TIMEOUT_CYC = 4096,
  parameter logic [31:0] LFSR_TAPS   = 32'h80200003
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               go,
  input  logic [ADDR_WDTH:0]                 arr_size,
  input  logic [DATA_WDTH-1:0]               seed,
  sort_test_sequencer_if.master              bus,
  output logic                               bus_grant_sorter,
  output logic                               sort_start,
  input  logic                               sort_done,
  input  logic                               sort_err,
  output logic                               busy,
  output logic                               pass,
  output logic                               fail,
  output logic [2:0]                         err_code,
  output logic [$clog2(NUM_RUNS+1)-1:0]      run_count
);

  localparam int IW  = ADDR_WDTH + 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int RCW = $clog2(NUM_RUNS + 1);
  localparam logic [IW-1:0]        MAX_SIZE   = {1'b1, {ADDR_WDTH{1'b0}}};
  localparam logic [TW-1:0]        TIMER_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [RCW-1:0]       RUNS_L     = RCW'(NUM_RUNS);
  localparam logic [DATA_WDTH-1:0] TAPS       = DATA_WDTH'(LFSR_TAPS);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL_REQ, S_FILL_RESP, S_SORT, S_CHK_REQ, S_CHK_DATA, S_DONE
  } state_t;

  state_t               state, state_d;
  logic [IW-1:0]        idx, size_q, idx_inc;
  logic [DATA_WDTH-1:0] lfsr, lfsr_next, prev_word;
  logic [TW-1:0]        timer;
  logic                 aw_done, w_done, aw_hs, w_hs;
  logic                 start_seq, fill_adv, chk_adv, run_end;
  logic                 done_pass, done_fail, sum_ok;
  logic [2:0]           fail_code;

  assign idx_inc   = idx + 1'b1;
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign aw_hs     = bus.aw_valid && bus.aw_ready;
  assign w_hs      = bus.w_valid && bus.w_ready;

  // Bus and status outputs decode straight from state so reset clears them at once.
  assign bus.aw_valid     = (state == S_FILL_REQ) && !aw_done;
  assign bus.w_valid      = (state == S_FILL_REQ) && !w_done;
  assign bus.aw_address   = idx[ADDR_WDTH-1:0];
  assign bus.w_data       = lfsr;
  assign bus.b_ready      = (state == S_FILL_RESP);
  assign bus.ar_valid     = (state == S_CHK_REQ);
  assign bus.ar_address   = idx[ADDR_WDTH-1:0];
  assign bus.r_ready      = (state == S_CHK_DATA);
  assign bus_grant_sorter = (state == S_SORT);
  assign sort_start       = (state == S_SORT);
  assign busy             = (state != S_IDLE) && (state != S_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state decode plus the strobes that steer the datapath.
  always_comb begin
    state_d   = state;
    start_seq = 1'b0;
    fill_adv  = 1'b0;
    chk_adv   = 1'b0;
    run_end   = 1'b0;
    done_pass = 1'b0;
    done_fail = 1'b0;
    fail_code = 3'd0;
    case (state)
      S_IDLE, S_DONE: begin
        if (go) begin
          start_seq = 1'b1;
          if (arr_size == '0) begin
            state_d   = S_DONE;
            done_pass = 1'b1;
          end else if (arr_size > MAX_SIZE) begin
            state_d   = S_DONE;
            done_fail = 1'b1;
            fail_code = 3'd7;
          end else begin
            state_d = S_FILL_REQ;
          end
        end
      end
      S_FILL_REQ: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_d = S_FILL_RESP;
      end
      S_FILL_RESP: begin
        if (bus.b_valid) begin
          if (bus.b_resp != '0) begin
            state_d   = S_DONE;
            done_fail = 1'b1;
            fail_code = 3'd1;
          end else begin
            fill_adv = 1'b1;
            state_d  = (idx_inc == size_q) ? S_SORT : S_FILL_REQ;
          end
        end
      end
      S_SORT: begin
        // done is checked first so it wins over a coincident timeout
        if (sort_done) begin
          if (sort_err) begin
            state_d   = S_DONE;
            done_fail = 1'b1;
            fail_code = 3'd2;
          end else begin
            state_d = S_CHK_REQ;
          end
        end else if (timer == '0) begin
          state_d   = S_DONE;
          done_fail = 1'b1;
          fail_code = 3'd3;
        end
      end
      S_CHK_REQ: begin
        if (bus.ar_ready) state_d = S_CHK_DATA;
      end
      S_CHK_DATA: begin
        if (bus.r_valid) begin
          if (bus.r_resp != '0) begin
            state_d   = S_DONE;
            done_fail = 1'b1;
            fail_code = 3'd5;
          end else if ((idx != '0) && (bus.r_data < prev_word)) begin
            state_d   = S_DONE;
            done_fail = 1'b1;
            fail_code = 3'd4;
          end else if ((idx_inc == size_q) && !sum_ok) begin
            state_d   = S_DONE;
            done_fail = 1'b1;
            fail_code = 3'd6;
          end else if (idx_inc == size_q) begin
            chk_adv = 1'b1;
            run_end = 1'b1;
            if ((run_count + 1'b1) == RUNS_L) begin
              state_d   = S_DONE;
              done_pass = 1'b1;
            end else begin
              state_d = S_FILL_REQ;
            end
          end else begin
            chk_adv = 1'b1;
            state_d = S_CHK_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: element index, LFSR, previous word, handshake flags and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      size_q    <= '0;
      lfsr      <= '0;
      prev_word <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      run_count <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      if (start_seq) begin
        size_q    <= arr_size;
        lfsr      <= (seed == '0) ? {{(DATA_WDTH-1){1'b0}}, 1'b1} : seed;
        idx       <= '0;
        run_count <= '0;
        pass      <= 1'b0;
        fail      <= 1'b0;
        err_code  <= 3'd0;
      end
      if ((state == S_FILL_REQ) && (state_d == S_FILL_REQ)) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (fill_adv) begin
        lfsr <= lfsr_next;
        idx  <= (idx_inc == size_q) ? '0 : idx_inc;
      end
      if (chk_adv) begin
        prev_word <= bus.r_data;
        idx       <= run_end ? '0 : idx_inc;
      end
      if (run_end) run_count <= run_count + 1'b1;
      if (done_pass) pass <= 1'b1;
      if (done_fail) begin
        fail     <= 1'b1;
        err_code <= fail_code;
      end
    end
  end

  // Sort timeout down-counter, reloaded whenever the sorter does not own the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  timer <= TIMER_LOAD;
    else if (state != S_SORT)                 timer <= TIMER_LOAD;
    else if (timer != '0)                     timer <= timer - 1'b1;
  end

`ifdef SORT_SUM_CHECK_EN
  localparam int SW = DATA_WDTH + ADDR_WDTH;
  logic [SW-1:0] sum_wr, sum_rd;

  // Per-run sums of written and read words; a mismatch means lost or duplicated elements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_wr <= '0;
      sum_rd <= '0;
    end else if (start_seq || run_end) begin
      sum_wr <= '0;
      sum_rd <= '0;
    end else begin
      if (fill_adv) sum_wr <= sum_wr + SW'(lfsr);
      if (chk_adv)  sum_rd <= sum_rd + SW'(bus.r_data);
    end
  end

  assign sum_ok = ((sum_rd + SW'(bus.r_data)) == sum_wr);
`else
  assign sum_ok = 1'b1;
`endif

endmodule
